// File: rtl/countdown_timer.sv
// Countdown timer: loads a packed {mm, ss} preset, counts down once per tick,
// and flags expiry with a one-cycle done pulse and a sticky expired level.
module countdown_timer #(
   parameter int unsigned MAX_MIN = 59
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        load,
   input  logic [11:0] time_in,
   input  logic        start,
   input  logic        pause,
   input  logic        clear,
   output logic [11:0] time_out,
   output logic        running,
   output logic        expired,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      READY,
      RUN,
      PAUSE,
      EXPIRED
   } state_t;

   localparam logic [5:0] MAX_MM = 6'(MAX_MIN);
   localparam logic [5:0] MAX_SS = 6'd59;

   state_t     state_q, state_d;
   logic [5:0] mm_q, mm_d;
   logic [5:0] ss_q, ss_d;
   logic       done_q, done_d;

   logic [5:0] ld_mm, ld_ss;
   logic [5:0] dec_mm, dec_ss;

   // Each field saturates independently, so 12'hFFF loads as MAX_MIN:59.
   assign ld_mm = (time_in[11:6] > MAX_MM) ? MAX_MM : time_in[11:6];
   assign ld_ss = (time_in[5:0]  > MAX_SS) ? MAX_SS : time_in[5:0];

   always_comb begin
      dec_mm = mm_q;
      dec_ss = ss_q;
      if (ss_q != '0) begin
         dec_ss = ss_q - 6'd1;
      end else begin
         dec_mm = mm_q - 6'd1;
         dec_ss = MAX_SS;
      end
   end

   // Strict priority chain: an asserted-but-ignored command still consumes
   // the cycle, so lower-priority inputs never act alongside it.
   always_comb begin
      state_d = state_q;
      mm_d    = mm_q;
      ss_d    = ss_q;
      done_d  = 1'b0;
      if (clear) begin
         state_d = IDLE;
         mm_d    = '0;
         ss_d    = '0;
      end else if (load) begin
         mm_d    = ld_mm;
         ss_d    = ld_ss;
         state_d = ((ld_mm == '0) && (ld_ss == '0)) ? IDLE : READY;
      end else if (pause) begin
         if (state_q == RUN) begin
            state_d = PAUSE;
         end
      end else if (start) begin
         if ((state_q == READY) || (state_q == PAUSE)) begin
            state_d = RUN;
         end
      end else if (tick) begin
         if (state_q == RUN) begin
            mm_d = dec_mm;
            ss_d = dec_ss;
            if ((dec_mm == '0) && (dec_ss == '0)) begin
               state_d = EXPIRED;
               done_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mm_q    <= '0;
         ss_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mm_q    <= mm_d;
         ss_q    <= ss_d;
         done_q  <= done_d;
      end
   end

   assign time_out = {mm_q, ss_q};
   assign running  = (state_q == RUN);
   assign expired  = (state_q == EXPIRED);
   assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer with hand-computed expectations
// plus hand-written reset-abort and continuous-tick sequences.
module tb_countdown_timer;

   logic        clk;
   logic        rst;
   logic        tick;
   logic        load;
   logic [11:0] time_in;
   logic        start;
   logic        pause;
   logic        clear;
   logic [11:0] time_out;
   logic        running;
   logic        expired;
   logic        done;

   int unsigned total;
   int unsigned bad;

   countdown_timer #(.MAX_MIN(59)) dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .load     (load),
      .time_in  (time_in),
      .start    (start),
      .pause    (pause),
      .clear    (clear),
      .time_out (time_out),
      .running  (running),
      .expired  (expired),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cl;
      logic        ld;
      logic [11:0] tin;
      logic        pa;
      logic        st;
      logic        tk;
      logic [11:0] e_time;
      logic        e_run;
      logic        e_exp;
      logic        e_done;
   } vec_t;

   vec_t vecs[64];
   int   nvec;

   task automatic add(input logic cl, input logic ld, input logic [11:0] tin,
                      input logic pa, input logic st, input logic tk,
                      input logic [11:0] e_time, input logic e_run,
                      input logic e_exp, input logic e_done);
      vecs[nvec].cl     = cl;
      vecs[nvec].ld     = ld;
      vecs[nvec].tin    = tin;
      vecs[nvec].pa     = pa;
      vecs[nvec].st     = st;
      vecs[nvec].tk     = tk;
      vecs[nvec].e_time = e_time;
      vecs[nvec].e_run  = e_run;
      vecs[nvec].e_exp  = e_exp;
      vecs[nvec].e_done = e_done;
      nvec++;
   endtask

   task automatic check_outs(input string name, input logic [11:0] e_time,
                             input logic e_run, input logic e_exp, input logic e_done);
      total++;
      if ((time_out !== e_time) || (running !== e_run) ||
          (expired !== e_exp) || (done !== e_done)) begin
         bad++;
         $display("FAIL %s: got time=%h run=%b exp=%b done=%b, want time=%h run=%b exp=%b done=%b",
                  name, time_out, running, expired, done, e_time, e_run, e_exp, e_done);
      end
   endtask

   task automatic drive(input logic cl, input logic ld, input logic [11:0] tin,
                        input logic pa, input logic st, input logic tk);
      clear   = cl;
      load    = ld;
      time_in = tin;
      pause   = pa;
      start   = st;
      tick    = tk;
   endtask

   task automatic step(input logic cl, input logic ld, input logic [11:0] tin,
                       input logic pa, input logic st, input logic tk);
      drive(cl, ld, tin, pa, st, tk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      nvec  = 0;
      drive(0, 0, 12'h000, 0, 0, 0);
      rst = 1'b1;

      //   cl ld tin      pa st tk  time     run exp done
      add(0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0); // idle after reset
      add(0, 1, 12'h042, 0, 0, 0, 12'h042, 0, 0, 0); // load 01:02
      add(0, 0, 12'h000, 0, 1, 0, 12'h042, 1, 0, 0);
      add(0, 0, 12'h000, 0, 0, 1, 12'h041, 1, 0, 0);
      add(0, 0, 12'h000, 0, 0, 1, 12'h040, 1, 0, 0);
      add(0, 0, 12'h000, 0, 0, 1, 12'h03B, 1, 0, 0); // minute borrow -> 00:59
      add(0, 1, 12'h002, 0, 0, 0, 12'h002, 0, 0, 0); // load in RUN stops
      add(0, 0, 12'h000, 0, 1, 0, 12'h002, 1, 0, 0);
      add(0, 0, 12'h000, 0, 0, 1, 12'h001, 1, 0, 0);
      add(0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 1, 1); // expiry pulse
      add(0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0);
      add(0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 1, 0);
      add(0, 0, 12'h000, 0, 1, 1, 12'h000, 0, 1, 0);
      add(0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 1, 0);
      add(0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 1, 0);
      add(0, 1, 12'hFFF, 0, 0, 0, 12'hEFB, 0, 0, 0); // saturate 59:59
      add(0, 0, 12'h000, 0, 1, 0, 12'hEFB, 1, 0, 0);
      add(0, 0, 12'h000, 0, 0, 1, 12'hEFA, 1, 0, 0);
      add(0, 1, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0); // load zero -> IDLE
      add(0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 0, 0); // start ignored
      add(0, 1, 12'h07C, 0, 0, 0, 12'h07B, 0, 0, 0); // ss 60 clamps to 59
      add(0, 1, 12'h005, 0, 0, 0, 12'h005, 0, 0, 0);
      add(0, 0, 12'h000, 0, 1, 0, 12'h005, 1, 0, 0);
      add(0, 0, 12'h000, 1, 0, 1, 12'h005, 0, 0, 0); // pause beats tick
      add(0, 0, 12'h000, 0, 1, 1, 12'h005, 1, 0, 0); // start beats tick
      add(0, 0, 12'h000, 0, 0, 1, 12'h004, 1, 0, 0);
      add(0, 0, 12'h000, 1, 1, 0, 12'h004, 0, 0, 0); // pause beats start
      add(0, 0, 12'h000, 1, 1, 0, 12'h004, 0, 0, 0); // PAUSE unchanged
      add(0, 0, 12'h000, 0, 1, 0, 12'h004, 1, 0, 0);
      add(1, 1, 12'h0C3, 0, 0, 1, 12'h000, 0, 0, 0); // clear wins
      add(0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 0, 0);
      add(0, 1, 12'h0C3, 0, 0, 0, 12'h0C3, 0, 0, 0);
      add(0, 0, 12'h000, 0, 1, 1, 12'h0C3, 1, 0, 0);
      add(0, 0, 12'h000, 0, 0, 1, 12'h0C2, 1, 0, 0);
      add(1, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_outs("reset", 12'h000, 0, 0, 0);

      for (int i = 0; i < nvec; i++) begin
         step(vecs[i].cl, vecs[i].ld, vecs[i].tin, vecs[i].pa, vecs[i].st, vecs[i].tk);
         check_outs($sformatf("vec%0d", i), vecs[i].e_time, vecs[i].e_run,
                    vecs[i].e_exp, vecs[i].e_done);
      end

      // continuous tick: one decrement per clock, single done
      step(0, 1, 12'h003, 0, 0, 0);
      step(0, 0, 12'h000, 0, 1, 0);
      step(0, 0, 12'h000, 0, 0, 1);
      check_outs("cont_t1", 12'h002, 1, 0, 0);
      step(0, 0, 12'h000, 0, 0, 1);
      check_outs("cont_t2", 12'h001, 1, 0, 0);
      step(0, 0, 12'h000, 0, 0, 1);
      check_outs("cont_t3", 12'h000, 0, 1, 1);
      step(0, 0, 12'h000, 0, 0, 1);
      check_outs("cont_t4", 12'h000, 0, 1, 0);

      // asynchronous reset mid-RUN at 01:30
      step(0, 1, 12'h05E, 0, 0, 0);
      step(0, 0, 12'h000, 0, 1, 0);
      check_outs("pre_rst", 12'h05E, 1, 0, 0);
      drive(0, 0, 12'h000, 0, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      check_outs("async_rst", 12'h000, 0, 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 12'h000, 0, (i == 1), 1);
         check_outs($sformatf("post_rst%0d", i), 12'h000, 0, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
